// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation selects, control classes and instruction opcodes.
// Imported by the ALU decoder and the ALU datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ADD  = 2'b00,
    CLS_SUB  = 2'b01,
    CLS_FUNC = 2'b10,
    CLS_OR   = 2'b11
  } alu_cls_e;

  // Upper half re-encodes a subset of the lower ops; 1110/1111 are spare and decode to ADD.
  typedef enum logic [3:0] {
    OP_ADD     = 4'b0000,
    OP_SUB     = 4'b0001,
    OP_AND     = 4'b0010,
    OP_OR      = 4'b0011,
    OP_XOR     = 4'b0100,
    OP_SLL     = 4'b0101,
    OP_SRL     = 4'b0110,
    OP_SLT     = 4'b0111,
    OP_ALT_ADD = 4'b1000,
    OP_ALT_AND = 4'b1001,
    OP_ALT_OR  = 4'b1010,
    OP_ALT_SLL = 4'b1011,
    OP_ALT_SRL = 4'b1100,
    OP_ALT_SLT = 4'b1101,
    OP_RSV_E   = 4'b1110,
    OP_RSV_F   = 4'b1111
  } opcode_e;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational Opcode -> ALU operation table, used when main control selects
// the function class.
module alu_func_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_op_e    op
);

  always_comb begin
    op = ALU_ADD;
    case (opcode)
      OP_ADD:     op = ALU_ADD;
      OP_SUB:     op = ALU_SUB;
      OP_AND:     op = ALU_AND;
      OP_OR:      op = ALU_OR;
      OP_XOR:     op = ALU_XOR;
      OP_SLL:     op = ALU_SLL;
      OP_SRL:     op = ALU_SRL;
      OP_SLT:     op = ALU_SLT;
      OP_ALT_ADD: op = ALU_ADD;
      OP_ALT_AND: op = ALU_AND;
      OP_ALT_OR:  op = ALU_OR;
      OP_ALT_SLL: op = ALU_SLL;
      OP_ALT_SRL: op = ALU_SRL;
      OP_ALT_SLT: op = ALU_SLT;
      OP_RSV_E:   op = ALU_ADD;
      OP_RSV_F:   op = ALU_ADD;
      // Unknown input bits fall through to ADD rather than holding a stale value.
      default:    op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// ALU control decoder: muxes the main-control ALU class with the opcode table
// and registers the resulting operation select (one cycle of latency).
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALUControl,
  input  logic [3:0] Opcode,
  output logic [2:0] ALUOpCode
);

  alu_op_e func_op;
  alu_op_e next_op;
  alu_op_e op_q;

  alu_func_decode u_func_decode (
    .opcode (Opcode),
    .op     (func_op)
  );

  always_comb begin
    next_op = ALU_ADD;
    case (ALUControl)
      CLS_ADD:  next_op = ALU_ADD;
      CLS_SUB:  next_op = ALU_SUB;
      CLS_FUNC: next_op = func_op;
      CLS_OR:   next_op = ALU_OR;
      default:  next_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) op_q <= ALU_ADD;
    else       op_q <= next_op;
  end

  assign ALUOpCode = op_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: directed scenarios plus random traffic
// against a table-driven reference model.
module tb_alu_op_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] ALUControl;
  logic [3:0] Opcode;
  logic [2:0] ALUOpCode;

  int total = 0;
  int bad   = 0;

  // Expected op per opcode in the function class: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7.
  int unsigned func_tbl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 3, 5, 6, 7, 0, 0};

  alu_op_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .ALUControl (ALUControl),
    .Opcode     (Opcode),
    .ALUOpCode  (ALUOpCode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] ref_op(input logic r, input logic [1:0] c, input logic [3:0] o);
    int unsigned v;
    if (r) v = 0;
    else if (c == 2'd0) v = 0;
    else if (c == 2'd1) v = 1;
    else if (c == 2'd3) v = 3;
    else v = func_tbl[o];
    return v[2:0];
  endfunction

  // Drive one cycle of inputs and return 1 time unit after the capturing edge.
  task automatic cycle(input logic r, input logic [1:0] c, input logic [3:0] o);
    reset = r;
    ALUControl = c;
    Opcode = o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] exp;
    for (int unsigned i = 0; i < 2; i++) begin
      cycle(1'b1, 2'b10, 4'b0111);
      exp = 3'b000;
      total++;
      if (ALUOpCode !== exp) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, ALUOpCode, exp);
      end
    end
    cycle(1'b0, 2'b10, 4'b0111);
    exp = 3'b111;
    total++;
    if (ALUOpCode !== exp) begin
      bad++;
      $display("FAIL reset_release: got %b expected %b", ALUOpCode, exp);
    end
  endtask

  task automatic test_fixed_classes;
    logic [1:0] cls [3] = '{2'b00, 2'b01, 2'b11};
    logic [2:0] exp;
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(1'b0, cls[i], 4'b0000);
      exp = ref_op(1'b0, cls[i], 4'b0000);
      total++;
      if (ALUOpCode !== exp) begin
        bad++;
        $display("FAIL fixed_class cls=%b: got %b expected %b", cls[i], ALUOpCode, exp);
      end
    end
  endtask

  task automatic test_opcode_ignored;
    logic [2:0] exp;
    for (int unsigned i = 0; i < 16; i++) begin
      cycle(1'b0, 2'b01, 4'(i));
      exp = 3'b001;
      total++;
      if (ALUOpCode !== exp) begin
        bad++;
        $display("FAIL opcode_ignored op=%0d: got %b expected %b", i, ALUOpCode, exp);
      end
    end
  endtask

  task automatic test_func_decode;
    logic [3:0] ops  [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0010};
    logic [2:0] exps [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b010};
    for (int unsigned i = 0; i < 5; i++) begin
      cycle(1'b0, 2'b10, ops[i]);
      total++;
      if (ALUOpCode !== exps[i]) begin
        bad++;
        $display("FAIL func_decode op=%b: got %b expected %b", ops[i], ALUOpCode, exps[i]);
      end
    end
  endtask

  // Also checks the output holds its previous value until the capturing edge.
  task automatic test_full_table;
    logic [2:0] prev;
    logic [2:0] exp;
    prev = ALUOpCode;
    for (int unsigned i = 0; i < 16; i++) begin
      reset = 1'b0;
      ALUControl = 2'b10;
      Opcode = 4'(i);
      #1;
      total++;
      if (ALUOpCode !== prev) begin
        bad++;
        $display("FAIL full_table_latency op=%0d: got %b expected %b", i, ALUOpCode, prev);
      end
      @(posedge clk);
      #1;
      exp = ref_op(1'b0, 2'b10, 4'(i));
      total++;
      if (ALUOpCode !== exp) begin
        bad++;
        $display("FAIL full_table op=%0d: got %b expected %b", i, ALUOpCode, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_mid_reset;
    logic [2:0] exp;
    cycle(1'b0, 2'b10, 4'b0101);
    exp = 3'b101;
    total++;
    if (ALUOpCode !== exp) begin
      bad++;
      $display("FAIL mid_reset_pre: got %b expected %b", ALUOpCode, exp);
    end
    cycle(1'b1, 2'b10, 4'b0101);
    exp = 3'b000;
    total++;
    if (ALUOpCode !== exp) begin
      bad++;
      $display("FAIL mid_reset_assert: got %b expected %b", ALUOpCode, exp);
    end
    cycle(1'b0, 2'b10, 4'b0101);
    exp = 3'b101;
    total++;
    if (ALUOpCode !== exp) begin
      bad++;
      $display("FAIL mid_reset_release: got %b expected %b", ALUOpCode, exp);
    end
  endtask

  task automatic test_random;
    logic       r;
    logic [1:0] c;
    logic [3:0] o;
    logic [2:0] exp;
    for (int unsigned i = 0; i < 300; i++) begin
      r = ($urandom_range(15) == 0);
      c = 2'($urandom_range(3));
      o = 4'($urandom_range(15));
      cycle(r, c, o);
      exp = ref_op(r, c, o);
      total++;
      if (ALUOpCode !== exp) begin
        bad++;
        $display("FAIL random[%0d] r=%b cls=%b op=%b: got %b expected %b", i, r, c, o, ALUOpCode, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ALUControl = 2'b00;
    Opcode = 4'b0000;
    test_reset();
    test_fixed_classes();
    test_opcode_ignored();
    test_func_decode();
    test_full_table();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Decodes the main control unit's 2-bit ALU class (ALUControl) and the 4-bit instruction Opcode into the 3-bit ALU operation select (ALUOpCode).
- Sits between the main control FSM and the ALU in the multicycle datapath.
- Output is registered: one clock of latency, synchronous active-high reset.

Parameters:
- None. All widths are fixed: ALUControl 2, Opcode 4, ALUOpCode 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ALUControl  input  2  ALU class from main control.
- Opcode  input  4  instruction opcode field, bits [15:12] of IR.
- ALUOpCode  output  3  registered ALU operation select.

Behaviour:
ALU operation encoding (ALUOpCode):
- 000 ADD
- 001 SUB
- 010 AND
- 011 OR
- 100 XOR
- 101 SLL
- 110 SRL
- 111 SLT

Class decode (ALUControl):
- 00 -> ADD (PC increment, address calculation). Opcode is ignored.
- 01 -> SUB (branch compare). Opcode is ignored.
- 11 -> OR (immediate merge / upper-load path). Opcode is ignored.
- 10 -> function taken from Opcode, per the table below.

Opcode decode when ALUControl = 10:
- 0000 ADD
- 0001 SUB
- 0010 AND
- 0011 OR
- 0100 XOR
- 0101 SLL
- 0110 SRL
- 0111 SLT
- 1000 ADD
- 1001 AND
- 1010 OR
- 1011 SLL
- 1100 SRL
- 1101 SLT
- 1110 ADD
- 1111 ADD (default; no illegal-op trap)

Timing:
- Decode is purely combinational.
- The result is captured in the ALUOpCode register on every rising clk edge.
- Latency is exactly 1 cycle: inputs applied before edge N appear on ALUOpCode after edge N.
- No enable and no handshake; the register loads every cycle.

Reset:
- reset = 1 at a rising edge forces ALUOpCode = 000 (ADD), overriding any inputs.
- The first edge with reset = 0 loads the decoded value.
- Reset asserted mid-stream takes effect at the next edge only; there is no asynchronous clear.

Other rules:
- X/Z on any input bit must not latch: the case statement carries a default that resolves to ADD.
- Changing Opcode while ALUControl ≠ 10 has no effect on the output.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 8 ALU ops (ALU_ADD … ALU_SLT);
  - localparams for the 4 ALUControl classes (CLS_ADD, CLS_SUB, CLS_FUNC, CLS_OR);
  - localparams for the 16 opcodes.
- The ALU itself imports the same op constants.
- One natural sub-module: alu_func_decode, a combinational Opcode -> 3-bit op table.
- The top level handles class muxing and the output register.

Test Plan:
1. Reset: hold reset = 1 with ALUControl = 10, Opcode = 0111 for 2 edges -> ALUOpCode = 000. Release reset -> 111 after the next edge.
2. Fixed classes: Opcode = 0000; apply ALUControl 00, 01, 11, one per cycle -> ALUOpCode 000, 001, 011, each one edge after application.
3. Opcode ignored: ALUControl = 01; sweep Opcode 0000 to 1111 -> ALUOpCode stays 001 throughout.
4. Function decode: ALUControl = 10; apply Opcode 0001, 0011, 0111, 1111, 0010 -> 001, 011, 111, 000, 010 respectively.
5. Full table: ALUControl = 10, exhaustive sweep of all 16 opcodes -> outputs match the decode table. Checker compares the output against the previous cycle's inputs (1-cycle latency).
6. Mid-stream reset: with ALUControl = 10, Opcode = 0101 producing 101, assert reset for 1 cycle -> 000 on that edge. Deassert -> 101 restored on the following edge.
